// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
//
// Shared definitions for the systolic-array stream sequencer:
//   - sa_state_e    : sequencer state type (IDLE, LOAD_W, STREAM, DRAIN)
//   - ST_*          : the same encodings as plain logic [1:0] constants, used for
//                     the state register so it stays a plain vector
//   - drain_cycles(): number of zero-fill cycles after the last vector
//   - lane_lsb()    : bit offset of a lane inside a packed lane bus
// -----------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } sa_state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_LOAD_W = LOAD_W;
    localparam logic [1:0] ST_STREAM = STREAM;
    localparam logic [1:0] ST_DRAIN  = DRAIN;

    // After the last vector the skew line needs DEPTH-1 cycles to empty, and
    // the final diagonal needs DEPTH more cycles to ripple through the array.
    function automatic int drain_cycles(input int depth);
        return 2 * depth - 1;
    endfunction

    // Lane i of a packed bus occupies [lane_lsb(i, w) +: w].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// -----------------------------------------------------------------------------
// sa_skew_line
//
// Fixed-length delay line for one lane of data plus its valid bit. The total
// latency is DELAY+1 cycles: stage 0 is a capture register, followed by DELAY
// further register stages. Data is forced to zero when valid_in is low, so
// every bubble travelling down the line is an all-zero slot.
//
// Ports:
//   clk        system clock (rising edge)
//   rst        synchronous active-high reset, clears all stages
//   data_in    lane data, BIT_WIDTH bits
//   valid_in   lane data qualifier
//   data_out   delayed data (zero whenever valid_out is low)
//   valid_out  delayed qualifier
// -----------------------------------------------------------------------------
module sa_skew_line #(
    parameter int BIT_WIDTH = 16,
    parameter int DELAY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] data_in,
    input  logic                 valid_in,
    output logic [BIT_WIDTH-1:0] data_out,
    output logic                 valid_out
);

    localparam int STAGES = DELAY + 1;

    logic [BIT_WIDTH-1:0] data_reg [STAGES];
    logic [STAGES-1:0]    valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                data_reg[k] <= '0;
            end
            valid_reg <= '0;
        end else begin
            // Mask at the entry point so invalid slots never carry stale data.
            data_reg[0]  <= valid_in ? data_in : '0;
            valid_reg[0] <= valid_in;
            for (int k = 1; k < STAGES; k++) begin
                data_reg[k]  <= data_reg[k-1];
                valid_reg[k] <= valid_reg[k-1];
            end
        end
    end

    assign data_out  = data_reg[STAGES-1];
    assign valid_out = valid_reg[STAGES-1];

endmodule

// File: rtl/sa_stream_sequencer.sv
// -----------------------------------------------------------------------------
// sa_stream_sequencer
//
// Front-end sequencer for a DEPTH x DEPTH weight-stationary systolic array.
// A job is: start -> load DEPTH weight columns -> stream data vectors (skewed
// so that lane i lags lane 0 by i cycles) -> drain with zeros -> done pulse.
//
// Ports:
//   clk             system clock (rising edge)
//   rst             synchronous active-high reset; aborts a job, no done pulse
//   start           begins a job, only honoured in IDLE
//   wt_valid/ready  weight column handshake, ready only in LOAD_W
//   wt_col          weight column, lane i = [i*BIT_WIDTH +: BIT_WIDTH]
//   vec_valid/ready data vector handshake, ready only in STREAM
//   vec_in          unskewed data vector, same lane layout
//   vec_last        marks the final vector (only meaningful when accepted)
//   arr_control     weight-load enable, one cycle per accepted column
//   arr_wt          registered weight column (holds between loads)
//   arr_data        skewed data to the array, invalid lanes are zero
//   arr_lane_valid  per-lane qualifier for arr_data
//   busy            high in every state except IDLE
//   done            one-cycle pulse at the end of the drain
//   vec_count       vectors accepted in the current/last job, saturating
// -----------------------------------------------------------------------------
module sa_stream_sequencer
    import sa_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       wt_valid,
    output logic                       wt_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0] wt_col,
    input  logic                       vec_valid,
    output logic                       vec_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0] vec_in,
    input  logic                       vec_last,
    output logic                       arr_control,
    output logic [BIT_WIDTH*DEPTH-1:0] arr_wt,
    output logic [BIT_WIDTH*DEPTH-1:0] arr_data,
    output logic [DEPTH-1:0]           arr_lane_valid,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       vec_count
);

    localparam int DRAIN_CYCLES = drain_cycles(DEPTH);
    localparam int COL_W        = $clog2(DEPTH + 1);
    localparam int DRN_W        = $clog2(DRAIN_CYCLES + 1);

    localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(DEPTH - 1);
    localparam logic [DRN_W-1:0]     LAST_DRN  = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    // -------------------------------------------------------------------------
    // State and bookkeeping registers
    // -------------------------------------------------------------------------
    logic [1:0]                 state_reg;
    logic [1:0]                 state_next;
    logic [COL_W-1:0]           col_cnt_reg;
    logic [DRN_W-1:0]           drain_cnt_reg;
    logic [CNT_WIDTH-1:0]       vec_count_reg;
    logic                       arr_control_reg;
    logic [BIT_WIDTH*DEPTH-1:0] arr_wt_reg;
    logic                       done_reg;

    logic wt_fire;
    logic vec_fire;
    logic last_col;
    logic drain_end;

    // Ready depends on state only, so it can never combinationally loop back
    // through an upstream valid.
    assign wt_ready  = (state_reg == ST_LOAD_W);
    assign vec_ready = (state_reg == ST_STREAM);

    assign wt_fire   = wt_valid  && wt_ready;
    assign vec_fire  = vec_valid && vec_ready;
    assign last_col  = (col_cnt_reg == LAST_COL);
    assign drain_end = (state_reg == ST_DRAIN) && (drain_cnt_reg == LAST_DRN);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (wt_fire && last_col) begin
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // vec_last only counts when the vector is actually taken.
                if (vec_fire && vec_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            col_cnt_reg     <= '0;
            drain_cnt_reg   <= '0;
            vec_count_reg   <= '0;
            arr_control_reg <= 1'b0;
            arr_wt_reg      <= '0;
            done_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Weight path: one registered load pulse per accepted column; the
            // column stays on arr_wt so the array sees stable weights.
            arr_control_reg <= wt_fire;
            if (wt_fire) begin
                arr_wt_reg <= wt_col;
            end

            // Counters for a new job are cleared on the start edge so that
            // vec_count of the previous job stays readable while idle.
            if ((state_reg == ST_IDLE) && start) begin
                col_cnt_reg   <= '0;
                vec_count_reg <= '0;
            end else begin
                if (wt_fire) begin
                    col_cnt_reg <= col_cnt_reg + 1'b1;
                end
                if (vec_fire && (vec_count_reg != CNT_MAX)) begin
                    vec_count_reg <= vec_count_reg + 1'b1;
                end
            end

            if (state_reg == ST_DRAIN) begin
                drain_cnt_reg <= drain_cnt_reg + 1'b1;
            end else begin
                drain_cnt_reg <= '0;
            end

            done_reg <= drain_end;
        end
    end

    // -------------------------------------------------------------------------
    // Diagonal skew: lane i goes through a line of latency i+1. In DRAIN (and
    // in any bubble) vec_fire is low, so zeros with valid=0 are shifted in.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
            sa_skew_line #(
                .BIT_WIDTH (BIT_WIDTH),
                .DELAY     (gi)
            ) u_skew (
                .clk       (clk),
                .rst       (rst),
                .data_in   (vec_in[lane_lsb(gi, BIT_WIDTH) +: BIT_WIDTH]),
                .valid_in  (vec_fire),
                .data_out  (arr_data[lane_lsb(gi, BIT_WIDTH) +: BIT_WIDTH]),
                .valid_out (arr_lane_valid[gi])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign arr_control = arr_control_reg;
    assign arr_wt      = arr_wt_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign done        = done_reg;
    assign vec_count   = vec_count_reg;

endmodule

// File: tb/tb_sa_stream_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for sa_stream_sequencer: a DEPTH=4/BIT_WIDTH=16 instance for the main
// scenarios and a DEPTH=8/BIT_WIDTH=8 instance for the larger skew. Drivers
// push expected lane values (with the cycle they must appear), weight loads and
// done pulses into queues; one negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_sa_stream_sequencer;

    localparam int BW  = 16;
    localparam int D   = 4;
    localparam int BW8 = 8;
    localparam int D8  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DEPTH=4 instance
    logic              start, wt_valid, wt_ready, vec_valid, vec_ready, vec_last;
    logic [BW*D-1:0]   wt_col, vec_in, arr_wt, arr_data;
    logic              arr_control, busy, done;
    logic [D-1:0]      arr_lane_valid;
    logic [15:0]       vec_count;

    // DEPTH=8 instance
    logic              start_8, wt_valid_8, wt_ready_8, vec_valid_8, vec_ready_8, vec_last_8;
    logic [BW8*D8-1:0] wt_col_8, vec_in_8, arr_wt_8, arr_data_8;
    logic              arr_control_8, busy_8, done_8;
    logic [D8-1:0]     arr_lane_valid_8;
    logic [15:0]       vec_count_8;

    sa_stream_sequencer #(.BIT_WIDTH(BW), .DEPTH(D), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_col(wt_col),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_in(vec_in), .vec_last(vec_last),
        .arr_control(arr_control), .arr_wt(arr_wt), .arr_data(arr_data),
        .arr_lane_valid(arr_lane_valid), .busy(busy), .done(done), .vec_count(vec_count)
    );

    sa_stream_sequencer #(.BIT_WIDTH(BW8), .DEPTH(D8), .CNT_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst), .start(start_8),
        .wt_valid(wt_valid_8), .wt_ready(wt_ready_8), .wt_col(wt_col_8),
        .vec_valid(vec_valid_8), .vec_ready(vec_ready_8), .vec_in(vec_in_8), .vec_last(vec_last_8),
        .arr_control(arr_control_8), .arr_wt(arr_wt_8), .arr_data(arr_data_8),
        .arr_lane_valid(arr_lane_valid_8), .busy(busy_8), .done(done_8), .vec_count(vec_count_8)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct { logic [15:0] d; int c; } lane_exp_t;
    typedef struct { logic [63:0] w; int c; } wt_exp_t;
    typedef struct { int c; int cnt; } done_exp_t;

    lane_exp_t lane_q  [D][$];
    lane_exp_t lane8_q [D8][$];
    wt_exp_t   wt_q[$];
    done_exp_t done_q[$];
    done_exp_t done8_q[$];
    int        ctrl8_seen = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        lane_exp_t le;
        wt_exp_t   we;
        done_exp_t de;
        for (int i = 0; i < D; i++) begin
            if (arr_lane_valid[i]) begin
                if (lane_q[i].size() == 0) begin
                    chk($sformatf("d4 lane%0d unexpected valid", i), 64'd1, 64'd0);
                end else begin
                    le = lane_q[i].pop_front();
                    chk($sformatf("d4 lane%0d data", i), 64'(arr_data[i*BW +: BW]), 64'(le.d));
                    chk($sformatf("d4 lane%0d cycle", i), 64'(cyc), 64'(le.c));
                end
            end else begin
                chk($sformatf("d4 lane%0d invalid zero", i), 64'(arr_data[i*BW +: BW]), 64'd0);
            end
        end
        for (int i = 0; i < D8; i++) begin
            if (arr_lane_valid_8[i]) begin
                if (lane8_q[i].size() == 0) begin
                    chk($sformatf("d8 lane%0d unexpected valid", i), 64'd1, 64'd0);
                end else begin
                    le = lane8_q[i].pop_front();
                    chk($sformatf("d8 lane%0d data", i), 64'(arr_data_8[i*BW8 +: BW8]), 64'(le.d));
                    chk($sformatf("d8 lane%0d cycle", i), 64'(cyc), 64'(le.c));
                end
            end else begin
                chk($sformatf("d8 lane%0d invalid zero", i), 64'(arr_data_8[i*BW8 +: BW8]), 64'd0);
            end
        end
        if (arr_control) begin
            if (wt_q.size() == 0) begin
                chk("d4 unexpected arr_control", 64'd1, 64'd0);
            end else begin
                we = wt_q.pop_front();
                chk("d4 arr_wt", arr_wt, we.w);
                chk("d4 arr_control cycle", 64'(cyc), 64'(we.c));
            end
        end
        if (arr_control_8) ctrl8_seen++;
        if (done) begin
            if (done_q.size() == 0) begin
                chk("d4 unexpected done", 64'd1, 64'd0);
            end else begin
                de = done_q.pop_front();
                chk("d4 done cycle", 64'(cyc), 64'(de.c));
                chk("d4 vec_count at done", 64'(vec_count), 64'(de.cnt));
            end
        end
        if (done_8) begin
            if (done8_q.size() == 0) begin
                chk("d8 unexpected done", 64'd1, 64'd0);
            end else begin
                de = done8_q.pop_front();
                chk("d8 done cycle", 64'(cyc), 64'(de.c));
                chk("d8 vec_count at done", 64'(vec_count_8), 64'(de.cnt));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Drivers (DEPTH=4 instance); all entered and left just after a negedge
    // -------------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_col(input logic [63:0] c);
        int      n = 0;
        wt_exp_t e;
        wt_col   = c;
        wt_valid = 1'b1;
        while (!wt_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wt_ready) begin
            chk("d4 wt_ready timeout", 64'd0, 64'd1);
        end else begin
            e.w = c;
            e.c = cyc + 1;
            wt_q.push_back(e);
            $display("col accepted 0x%016h at edge %0d", c, cyc + 1);
        end
        @(negedge clk);
        wt_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [63:0] v, input logic last, input int exp_count);
        int        n = 0;
        int        t;
        lane_exp_t le;
        done_exp_t de;
        vec_in    = v;
        vec_last  = last;
        vec_valid = 1'b1;
        while (!vec_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!vec_ready) begin
            chk("d4 vec_ready timeout", 64'd0, 64'd1);
        end else begin
            t = cyc + 1;
            for (int i = 0; i < D; i++) begin
                le.d = v[i*BW +: BW];
                le.c = t + i;
                lane_q[i].push_back(le);
            end
            if (last) begin
                de.c   = t + 2*D - 1;
                de.cnt = exp_count;
                done_q.push_back(de);
            end
            $display("vec accepted 0x%016h last=%0d at edge %0d", v, last, t);
        end
        @(negedge clk);
        vec_valid = 1'b0;
        vec_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("d4 done timeout", 64'd0, 64'd1);
        else $display("done seen at cycle %0d, vec_count %0d", cyc, vec_count);
        @(negedge clk);
    endtask

    task automatic load_cols(input logic [63:0] base);
        for (int k = 0; k < D; k++) send_col(base + 64'(k));
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [63:0] one;
        int          n;
        int          acc;
        int          t;
        lane_exp_t   le;
        done_exp_t   de;

        start = 0; wt_valid = 0; wt_col = '0; vec_valid = 0; vec_in = '0; vec_last = 0;
        start_8 = 0; wt_valid_8 = 0; wt_col_8 = '0; vec_valid_8 = 0; vec_in_8 = '0; vec_last_8 = 0;
        rst = 1'b1;
        idle(3);

        // Reset state
        chk("reset flags {ctrl,busy,done,wt_rdy,vec_rdy}",
            64'({arr_control, busy, done, wt_ready, vec_ready}), 64'd0);
        chk("reset arr_wt", arr_wt, 64'd0);
        chk("reset arr_data", arr_data, 64'd0);
        chk("reset arr_lane_valid", 64'(arr_lane_valid), 64'd0);
        chk("reset vec_count", 64'(vec_count), 64'd0);
        rst = 1'b0;
        idle(1);

        // 1. Basic job: one-hot columns lane 3,2,1,0, four vectors
        pulse_start();
        chk("t1 {busy,wt_rdy,vec_rdy} in LOAD_W", 64'({busy, wt_ready, vec_ready}), 64'b110);
        one = 64'd1;
        for (int k = 0; k < D; k++) send_col(one << (BW * (D - 1 - k)));
        chk("t1 {wt_rdy,vec_rdy} after 4th column", 64'({wt_ready, vec_ready}), 64'b01);
        send_vec(64'h0003_0002_0001_0000, 1'b0, 0);
        send_vec(64'h0007_0006_0005_0004, 1'b0, 0);
        send_vec(64'h000b_000a_0009_0008, 1'b0, 0);
        send_vec(64'h000f_000e_000d_000c, 1'b1, 4);
        chk("t1 {busy,vec_rdy} in DRAIN", 64'({busy, vec_ready}), 64'b10);
        wait_done();
        chk("t1 busy after done", 64'(busy), 64'd0);
        chk("t1 vec_count held", 64'(vec_count), 64'd4);

        // 2. Weight backpressure, 3. stream bubbles
        pulse_start();
        for (int k = 0; k < D; k++) begin
            send_col(64'hA0A0_B0B0_C0C0_D0D0 + 64'(k * 3));
            if (k < D - 1) begin
                idle(1);
                chk("t2 arr_control low in gap", 64'(arr_control), 64'd0);
                chk("t2 arr_wt holds in gap", arr_wt, 64'hA0A0_B0B0_C0C0_D0D0 + 64'(k * 3));
                chk("t2 {wt_rdy,vec_rdy} still LOAD_W", 64'({wt_ready, vec_ready}), 64'b10);
            end
        end
        chk("t2 {wt_rdy,vec_rdy} after 4th column", 64'({wt_ready, vec_ready}), 64'b01);
        send_vec(64'h1111_2222_3333_4444, 1'b0, 0);
        idle(2);
        send_vec(64'h5555_6666_7777_8888, 1'b0, 0);
        idle(2);
        send_vec(64'h9999_AAAA_BBBB_CCCC, 1'b1, 3);
        wait_done();
        chk("t3 vec_count", 64'(vec_count), 64'd3);

        // 4. Reset with two vectors inside the skew line
        pulse_start();
        load_cols(64'h0123_4567_89AB_CDEF);
        send_vec(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0);
        send_vec(64'h0BAD_0BAD_0BAD_0BAD, 1'b0, 0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < D; i++) lane_q[i].delete();
        @(negedge clk);
        chk("t4 arr_data after reset", arr_data, 64'd0);
        chk("t4 arr_lane_valid after reset", 64'(arr_lane_valid), 64'd0);
        chk("t4 {busy,done} after reset", 64'({busy, done}), 64'd0);
        chk("t4 vec_count after reset", 64'(vec_count), 64'd0);
        rst = 1'b0;
        idle(12);

        // 5. Clean job with start in STREAM and vec_last without vec_valid
        pulse_start();
        load_cols(64'h0F0F_0E0E_0D0D_0C0C);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        chk("t5 start ignored in STREAM", 64'({busy, wt_ready, vec_ready}), 64'b101);
        vec_last = 1'b1;
        idle(2);
        vec_last = 1'b0;
        chk("t5 unqualified vec_last ignored", 64'({busy, wt_ready, vec_ready}), 64'b101);
        send_vec(64'h0102_0304_0506_0708, 1'b0, 0);
        send_vec(64'h1112_1314_1516_1718, 1'b1, 2);
        wait_done();
        idle(3);
        chk("t5 vec_count holds in IDLE", 64'(vec_count), 64'd2);

        // 6. DEPTH=8, BIT_WIDTH=8 instance
        start_8 = 1'b1;
        @(negedge clk);
        start_8 = 1'b0;
        wt_valid_8 = 1'b1;
        wt_col_8   = 64'h0102_0304_0506_0708;
        n = 0;
        acc = 0;
        while (acc < D8 && n < 40) begin
            if (wt_ready_8) acc++;
            @(negedge clk);
            n++;
        end
        wt_valid_8 = 1'b0;
        chk("t6 columns accepted", 64'(acc), 64'd8);
        idle(1);
        chk("t6 arr_control pulses", 64'(ctrl8_seen), 64'd8);
        vec_in_8    = 64'h8877_6655_4433_2211;
        vec_last_8  = 1'b1;
        vec_valid_8 = 1'b1;
        n = 0;
        while (!vec_ready_8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!vec_ready_8) begin
            chk("t6 vec_ready timeout", 64'd0, 64'd1);
        end else begin
            t = cyc + 1;
            for (int i = 0; i < D8; i++) begin
                le.d = 16'(vec_in_8[i*BW8 +: BW8]);
                le.c = t + i;
                lane8_q[i].push_back(le);
            end
            de.c   = t + 2*D8 - 1;
            de.cnt = 1;
            done8_q.push_back(de);
            $display("d8 vec accepted 0x%016h at edge %0d", vec_in_8, t);
        end
        @(negedge clk);
        vec_valid_8 = 1'b0;
        vec_last_8  = 1'b0;
        n = 0;
        while (!done_8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done_8) chk("t6 done timeout", 64'd0, 64'd1);
        idle(2);

        // Everything that was expected must have been seen
        n = 0;
        for (int i = 0; i < D; i++) n += lane_q[i].size();
        for (int i = 0; i < D8; i++) n += lane8_q[i].size();
        chk("lane entries never seen", 64'(n), 64'd0);
        chk("weight loads never seen", 64'(wt_q.size()), 64'd0);
        chk("done pulses never seen", 64'(done_q.size() + done8_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_stream_sequencer.md
Name: sa_stream_sequencer

Overview:
Parametrised front-end sequencer for the weight-stationary systolic array (TPU/MMU). It takes weight columns and data vectors over valid/ready handshakes and loads the DEPTH weight columns with the array control asserted. It then streams data vectors with the diagonal skew applied in hardware, where lane i is delayed i cycles. It flushes the array and signals completion. This replaces hand-built diagonal/"x" stimulus, and invalid lanes are always driven as zeros.

Parameters:
BIT_WIDTH, 16, width of one weight/data lane
DEPTH, 4, array dimension (lanes/rows/columns), legal range 2..16
CNT_WIDTH, 16, width of the accepted-vector counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  pulse, begins a job (honoured only in IDLE)
wt_valid  in  1  wt_col holds a valid weight column
wt_ready  out  1  sequencer accepts a weight column this cycle
wt_col  in  BIT_WIDTH*DEPTH  weight column, lane i = bits [i*BIT_WIDTH +: BIT_WIDTH]
vec_valid  in  1  vec_in holds a valid data vector
vec_ready  out  1  sequencer accepts a data vector this cycle
vec_in  in  BIT_WIDTH*DEPTH  data vector, unskewed, lane i as above
vec_last  in  1  qualifies the final vector of the job
arr_control  out  1  array weight-load enable (one cycle per accepted column)
arr_wt  out  BIT_WIDTH*DEPTH  weight column to the array
arr_data  out  BIT_WIDTH*DEPTH  skewed data to the array
arr_lane_valid  out  DEPTH  per-lane valid for arr_data
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of drain
vec_count  out  CNT_WIDTH  vectors accepted in current/last job, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; skew registers 0; vec_count 0. Reset mid-job aborts immediately, and there is no done pulse.
- Handshake: a transfer occurs when valid && ready at a rising edge. The ready signals are functions of state only.
- IDLE: wt_ready=vec_ready=0. On start, go to LOAD_W, clear vec_count and the column counter. start in any other state is ignored.
- LOAD_W: wt_ready=1.
  - An accepted column is registered, so arr_wt=wt_col and arr_control=1 in the following cycle.
  - A cycle with no transfer gives arr_control=0 next cycle. arr_wt holds its last value, and the array must hold its weights.
  - After the DEPTH-th accepted column, go to STREAM. wt_ready drops in the same cycle as that transfer's edge.
- STREAM: vec_ready=1.
  - An accepted vector at edge t enters the skew line. Lane i appears on arr_data with arr_lane_valid[i]=1 in the cycle after edge t+i, so lane 0 latency is 1 cycle and lane DEPTH-1 latency is DEPTH cycles.
  - Bubble cycles (no transfer) insert zero/invalid lanes and preserve the timing of older vectors.
  - vec_count increments per accepted vector and saturates at 2^CNT_WIDTH-1.
  - An accepted vector with vec_last goes to DRAIN.
  - vec_last on a non-accepted cycle is ignored.
- DRAIN: vec_ready=0; zeros are shifted in for DRAIN_CYCLES = 2*DEPTH-1 cycles. This flushes the skew (DEPTH-1 cycles) and propagates through the array (DEPTH cycles). Then done=1 for one cycle and the state returns to IDLE. vec_count holds until the next start.
- Invalid lanes on arr_data are always 0, never X.
- Data and weights pass through unchanged; there is no arithmetic on lanes.

Decomposition:
- Package sa_pkg:
  - state enum {IDLE, LOAD_W, STREAM, DRAIN}
  - lane slice helper function
  - DRAIN_CYCLES function of DEPTH
- Sub-module sa_skew_line: parametrised delay line, generics BIT_WIDTH and DELAY, with data+valid. The sequencer instantiates it once per lane with DELAY=i; DELAY=0 is a pass-through register stage, giving latency 1.

Test Plan:
1. Basic job (DEPTH=4):
   - Stimulus: start; columns 0x0001 one-hot (lane 3,2,1,0 in successive beats); vectors [3,2,1,0],[7,6,5,4],[b,a,9,8],[f,e,d,c] with last on the 4th.
   - Required response: arr_control high for exactly 4 cycles. arr_data lane i of vector k appears at cycle (accept_k)+1+i. done fires 7 cycles after the last accept. vec_count=4.
2. Weight backpressure: wt_valid toggled 1,0,1,0... → arr_control pattern mirrors transfers. The state enters STREAM only after the 4th column; arr_wt holds during gaps.
3. Stream bubbles: vec_valid low for 2 cycles between vectors → 2 all-invalid zero slots per lane, shifted i cycles on lane i. No data loss.
4. Reset mid-STREAM: assert rst with 2 vectors in the skew → next cycle IDLE, arr_data=0, arr_lane_valid=0, busy=0, no done. A subsequent start runs a clean job.
5. start during STREAM and vec_last without vec_valid → both ignored. The job ends only on an accepted vec_last.
6. DEPTH=8, BIT_WIDTH=8 instance: one vector of 8 lanes → lane 7 latency is 8 cycles. done arrives 15 cycles after the last accept.
